// File: rtl/hexa_router_pkg.sv
// Shared definitions for hexa_router_wh: port indices, flit field positions and XY routing.
package hexa_router_pkg;

    localparam int unsigned NPORTS = 5;
    localparam int unsigned PORT_W = 3;

    localparam logic [PORT_W-1:0] PORT_XP = 3'd0;
    localparam logic [PORT_W-1:0] PORT_XM = 3'd1;
    localparam logic [PORT_W-1:0] PORT_YP = 3'd2;
    localparam logic [PORT_W-1:0] PORT_YM = 3'd3;
    localparam logic [PORT_W-1:0] PORT_PE = 3'd4;

    function automatic int unsigned head_bit(input int unsigned flit_w);
        return flit_w - 1;
    endfunction

    function automatic int unsigned tail_bit(input int unsigned flit_w);
        return flit_w - 2;
    endfunction

    // Dimension-ordered routing: resolve X first, then Y, then deliver locally.
    function automatic logic [PORT_W-1:0] route_xy(input int unsigned dx, input int unsigned dy,
                                                   input int unsigned xcor,
                                                   input int unsigned ycor);
        if (dx > xcor) return PORT_XP;
        if (dx < xcor) return PORT_XM;
        if (dy > ycor) return PORT_YP;
        if (dy < ycor) return PORT_YM;
        return PORT_PE;
    endfunction

endpackage

// File: rtl/hexa_in_fifo.sv
// Input flit FIFO; the caller guarantees push only when not full (or popping) and pop only when
// not empty.
module hexa_in_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned FLIT_W = 34
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [FLIT_W-1:0] i_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [FLIT_W-1:0] o_head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (!i_push && i_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/hexa_router_wh.sv
// 5-port wormhole mesh router: XY routing, round-robin output arbitration with packet locking,
// credit flow control. Define HEXA_ERR_CHECK_EN to enable overflow/orphan-flit error checking.
module hexa_router_wh
    import hexa_router_pkg::*;
#(
    parameter int unsigned XCOR    = 2,
    parameter int unsigned YCOR    = 2,
    parameter int unsigned COORD_W = 4,
    parameter int unsigned FLIT_W  = 34,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CREDITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        in_valid,
    input  logic [NPORTS*FLIT_W-1:0] in_flit,
    output logic [NPORTS-1:0]        in_credit,
    output logic [NPORTS-1:0]        out_valid,
    output logic [NPORTS*FLIT_W-1:0] out_flit,
    input  logic [NPORTS-1:0]        out_credit,
    output logic                     err
);
    localparam int unsigned CNT_W = $clog2(CREDITS + 1);
    localparam int unsigned HB    = head_bit(FLIT_W);
    localparam int unsigned TB    = tail_bit(FLIT_W);

    logic [FLIT_W-1:0] w_head [NPORTS];
    logic [FLIT_W-1:0] w_out  [NPORTS];
    logic [NPORTS-1:0] w_empty, w_full, w_push, w_pop, w_is_head, w_orphan, w_req, w_send;
    logic [PORT_W-1:0] w_route [NPORTS];
    logic [PORT_W-1:0] w_sel   [NPORTS];
    logic [PORT_W-1:0] r_route [NPORTS];
    logic [PORT_W-1:0] r_ptr   [NPORTS];
    logic [PORT_W-1:0] r_owner [NPORTS];
    logic [CNT_W-1:0]  r_cred  [NPORTS];
    logic [NPORTS-1:0] r_lock, r_out_valid;
    logic [NPORTS*FLIT_W-1:0] r_out_flit;
`ifdef HEXA_ERR_CHECK_EN
    logic [NPORTS-1:0] r_open;
    logic              r_err;
`endif

    for (genvar i = 0; i < NPORTS; i++) begin : g_in
        // Full FIFO still accepts when the head leaves in the same cycle.
        assign w_push[i] = in_valid[i] && (!w_full[i] || w_pop[i]);

        hexa_in_fifo #(
            .DEPTH  (DEPTH),
            .FLIT_W (FLIT_W)
        ) u_fifo (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_push  (w_push[i]),
            .i_pop   (w_pop[i]),
            .i_data  (in_flit[i*FLIT_W +: FLIT_W]),
            .o_full  (w_full[i]),
            .o_empty (w_empty[i]),
            .o_head  (w_head[i])
        );

        assign w_is_head[i] = w_head[i][HB];
        assign w_route[i]   = w_is_head[i]
            ? route_xy(32'(w_head[i][2*COORD_W-1:COORD_W]), 32'(w_head[i][COORD_W-1:0]),
                       XCOR, YCOR)
            : r_route[i];
`ifdef HEXA_ERR_CHECK_EN
        assign w_orphan[i] = !w_empty[i] && !w_is_head[i] && !r_open[i];
`else
        assign w_orphan[i] = 1'b0;
`endif
        assign w_req[i] = !w_empty[i] && !w_orphan[i];
    end

    always_comb begin
        int unsigned idx;
        idx    = 0;
        w_send = '0;
        w_pop  = w_orphan;
        for (int o = 0; o < NPORTS; o++) begin
            w_sel[o] = r_owner[o];
            if (r_lock[o]) begin
                w_send[o] = w_req[r_owner[o]] && (w_route[r_owner[o]] == PORT_W'(o));
            end else begin
                // Scan furthest-first so the candidate nearest ptr+1 is assigned last and wins.
                for (int unsigned k = NPORTS; k > 0; k--) begin
                    idx = 32'(r_ptr[o]) + k;
                    if (idx >= NPORTS) idx = idx - NPORTS;
                    if (w_req[idx] && (w_route[idx] == PORT_W'(o))) begin
                        w_sel[o]  = PORT_W'(idx);
                        w_send[o] = 1'b1;
                    end
                end
            end
            if (r_cred[o] == '0) w_send[o] = 1'b0;
            if (w_send[o]) w_pop[w_sel[o]] = 1'b1;
            w_out[o] = w_head[w_sel[o]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock      <= '0;
            r_out_valid <= '0;
            r_out_flit  <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                r_cred[p]  <= CNT_W'(CREDITS);
                r_ptr[p]   <= '0;
                r_owner[p] <= '0;
                r_route[p] <= '0;
            end
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                r_out_valid[o]                  <= w_send[o];
                r_out_flit[o*FLIT_W +: FLIT_W] <= w_send[o] ? w_out[o] : '0;
                if (w_send[o] && !out_credit[o]) begin
                    r_cred[o] <= r_cred[o] - 1'b1;
                end else if (!w_send[o] && out_credit[o] && (r_cred[o] < CNT_W'(CREDITS))) begin
                    r_cred[o] <= r_cred[o] + 1'b1;
                end
                if (w_send[o]) begin
                    if (!r_lock[o]) r_ptr[o] <= w_sel[o];
                    if (w_out[o][TB]) begin
                        r_lock[o] <= 1'b0;
                    end else if (w_out[o][HB]) begin
                        r_lock[o]  <= 1'b1;
                        r_owner[o] <= w_sel[o];
                    end
                end
            end
            for (int i = 0; i < NPORTS; i++) begin
                if (w_pop[i] && w_is_head[i]) r_route[i] <= w_route[i];
            end
        end
    end

`ifdef HEXA_ERR_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_open <= '0;
            r_err  <= 1'b0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (w_pop[i] && !w_orphan[i]) begin
                    if (w_head[i][TB])           r_open[i] <= 1'b0;
                    else if (w_head[i][HB])      r_open[i] <= 1'b1;
                end
            end
            if (|(in_valid & w_full & ~w_pop) || |w_orphan) r_err <= 1'b1;
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign in_credit = rst ? '0 : w_pop;
    assign out_valid = r_out_valid;
    assign out_flit  = r_out_flit;

endmodule

// File: tb/tb_hexa_router_wh.sv
// Directed self-checking bench for hexa_router_wh (XCOR=2, YCOR=2, DEPTH=4, CREDITS=4).
module tb_hexa_router_wh;
    localparam int FW = 34;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    in_valid;
    logic [5*FW-1:0] in_flit;
    logic [4:0]    in_credit;
    logic [4:0]    out_valid;
    logic [5*FW-1:0] out_flit;
    logic [4:0]    out_credit;
    logic          err;

    int errs   = 0;
    int checks = 0;

    hexa_router_wh dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_flit    (in_flit),
        .in_credit  (in_credit),
        .out_valid  (out_valid),
        .out_flit   (out_flit),
        .out_credit (out_credit),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input logic h, input logic t, input logic [7:0] tag,
                                         input logic [3:0] dx, input logic [3:0] dy);
        return {h, t, 16'h0, tag, dx, dy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [FW-1:0] f);
        in_valid[p]         = 1'b1;
        in_flit[p*FW +: FW] = f;
    endtask

    task automatic clear_in();
        in_valid = '0;
        in_flit  = '0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        out_credit = '0;
        clear_in();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 5'b0) begin errs++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_flit !== '0) begin errs++; $display("FAIL rst_out_flit: got %h want 0", out_flit); end
        checks++; if (in_credit !== 5'b0) begin errs++; $display("FAIL rst_in_credit: got %b want 0", in_credit); end
        checks++; if (err !== 1'b0) begin errs++; $display("FAIL rst_err: got %b want 0", err); end
    endtask

    task automatic test_single_flit();
        logic [FW-1:0] f;
        do_reset();
        f = mk(1'b1, 1'b1, 8'h11, 4'd3, 4'd2);
        drive(4, f);
        tick();
        clear_in();
        checks++; if (in_credit !== 5'b10000) begin errs++; $display("FAIL single_credit: got %b want 10000", in_credit); end
        checks++; if (out_valid !== 5'b0) begin errs++; $display("FAIL single_early: got %b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 5'b00001) begin errs++; $display("FAIL single_valid: got %b want 00001", out_valid); end
        checks++; if (out_flit[0 +: FW] !== f) begin errs++; $display("FAIL single_flit: got %h want %h", out_flit[0 +: FW], f); end
        tick();
        checks++; if (out_valid !== 5'b0) begin errs++; $display("FAIL single_once: got %b want 0", out_valid); end
    endtask

    task automatic test_all_ports();
        logic [FW-1:0] f [5];
        do_reset();
        f[0] = mk(1'b1, 1'b1, 8'h20, 4'd3, 4'd2);  // from pe -> x+
        f[1] = mk(1'b1, 1'b1, 8'h21, 4'd1, 4'd2);  // from x+ -> x-
        f[2] = mk(1'b1, 1'b1, 8'h22, 4'd2, 4'd3);  // from x- -> y+
        f[3] = mk(1'b1, 1'b1, 8'h23, 4'd2, 4'd1);  // from y+ -> y-
        f[4] = mk(1'b1, 1'b1, 8'h24, 4'd2, 4'd2);  // from y- -> pe
        drive(4, f[0]);
        drive(0, f[1]);
        drive(1, f[2]);
        drive(2, f[3]);
        drive(3, f[4]);
        tick();
        clear_in();
        checks++; if (in_credit !== 5'b11111) begin errs++; $display("FAIL all_credit: got %b want 11111", in_credit); end
        tick();
        checks++; if (out_valid !== 5'b11111) begin errs++; $display("FAIL all_valid: got %b want 11111", out_valid); end
        for (int o = 0; o < 5; o++) begin
            checks++;
            if (out_flit[o*FW +: FW] !== f[o]) begin
                errs++; $display("FAIL all_flit%0d: got %h want %h", o, out_flit[o*FW +: FW], f[o]);
            end
        end
    endtask

    task automatic test_wormhole();
        logic [FW-1:0] a [3];
        logic [FW-1:0] b [3];
        logic [FW-1:0] exp_q [6];
        logic [FW-1:0] got [$];
        logic [FW-1:0] obs;
        do_reset();
        out_credit = 5'b10000;
        a[0] = mk(1'b1, 1'b0, 8'hA0, 4'd2, 4'd2);
        a[1] = mk(1'b0, 1'b0, 8'hA1, 4'd0, 4'd0);
        a[2] = mk(1'b0, 1'b1, 8'hA2, 4'd0, 4'd0);
        b[0] = mk(1'b1, 1'b0, 8'hB0, 4'd2, 4'd2);
        b[1] = mk(1'b0, 1'b0, 8'hB1, 4'd0, 4'd0);
        b[2] = mk(1'b0, 1'b1, 8'hB2, 4'd0, 4'd0);
        exp_q = '{a[0], a[1], a[2], b[0], b[1], b[2]};
        for (int c = 0; c < 12; c++) begin
            clear_in();
            if (c < 3) drive(0, a[c]);
            if (c >= 1 && c < 4) drive(3, b[c-1]);
            tick();
            if (out_valid[4]) got.push_back(out_flit[4*FW +: FW]);
        end
        clear_in();
        out_credit = '0;
        checks++; if (got.size() !== 6) begin errs++; $display("FAIL worm_count: got %0d want 6", got.size()); end
        for (int k = 0; k < 6; k++) begin
            obs = (k < got.size()) ? got[k] : '0;
            checks++;
            if (obs !== exp_q[k]) begin errs++; $display("FAIL worm_order%0d: got %h want %h", k, obs, exp_q[k]); end
        end
    endtask

    task automatic test_credit_stall();
        int cnt = 0;
        logic [7:0] last = 8'hFF;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            clear_in();
            if (c < 6) drive(4, mk(1'b1, 1'b1, 8'(c), 4'd1, 4'd2));
            tick();
            if (out_valid[1]) begin cnt++; last = out_flit[FW+8 +: 8]; end
        end
        clear_in();
        checks++; if (cnt !== 4) begin errs++; $display("FAIL stall_count: got %0d want 4", cnt); end
        checks++; if (last !== 8'd3) begin errs++; $display("FAIL stall_last: got %0d want 3", last); end
        cnt = 0;
        out_credit = 5'b00010;
        tick();
        out_credit = '0;
        if (out_valid[1]) begin cnt++; last = out_flit[FW+8 +: 8]; end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (out_valid[1]) begin cnt++; last = out_flit[FW+8 +: 8]; end
        end
        checks++; if (cnt !== 1) begin errs++; $display("FAIL stall_resume: got %0d want 1", cnt); end
        checks++; if (last !== 8'd4) begin errs++; $display("FAIL stall_fifth: got %0d want 4", last); end
    endtask

    task automatic test_round_robin();
        logic [3:0] src [$];
        logic [3:0] obs;
        do_reset();
        out_credit = 5'b10000;
        for (int c = 0; c < 30; c++) begin
            clear_in();
            if (c < 4) drive(0, mk(1'b1, 1'b1, {4'd0, 4'(c)}, 4'd2, 4'd2));
            for (int p = 1; p < 4; p++) begin
                if (c >= 1 && c < 5) drive(p, mk(1'b1, 1'b1, {4'(p), 4'(c-1)}, 4'd2, 4'd2));
            end
            tick();
            if (out_valid[4]) src.push_back(out_flit[4*FW+12 +: 4]);
        end
        clear_in();
        out_credit = '0;
        checks++; if (src.size() !== 16) begin errs++; $display("FAIL rr_count: got %0d want 16", src.size()); end
        for (int k = 0; k < 16; k++) begin
            obs = (k < src.size()) ? src[k] : 4'hF;
            checks++;
            if (obs !== 4'(k % 4)) begin errs++; $display("FAIL rr_grant%0d: got %0d want %0d", k, obs, k % 4); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] tags [$];
        logic [7:0] exp_t [6];
        logic [7:0] obs;
        logic       exp_err;
`ifdef HEXA_ERR_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        exp_t = '{8'hF0, 8'hF1, 8'h00, 8'h01, 8'h02, 8'h03};
        do_reset();
        out_credit = 5'b10000;
        for (int c = 0; c < 20; c++) begin
            clear_in();
            if (c == 0) drive(0, mk(1'b1, 1'b0, 8'hF0, 4'd2, 4'd2));
            if (c >= 1 && c < 6) drive(2, mk(1'b1, 1'b1, 8'(c-1), 4'd2, 4'd2));
            if (c == 6) drive(0, mk(1'b0, 1'b1, 8'hF1, 4'd0, 4'd0));
            tick();
            if (out_valid[4]) tags.push_back(out_flit[4*FW+8 +: 8]);
            if (c == 4) begin
                checks++; if (err !== 1'b0) begin errs++; $display("FAIL ovf_err_early: got %b want 0", err); end
            end
        end
        clear_in();
        out_credit = '0;
        checks++; if (err !== exp_err) begin errs++; $display("FAIL ovf_err: got %b want %b", err, exp_err); end
        checks++; if (tags.size() !== 6) begin errs++; $display("FAIL ovf_count: got %0d want 6", tags.size()); end
        for (int k = 0; k < 6; k++) begin
            obs = (k < tags.size()) ? tags[k] : 8'hEE;
            checks++;
            if (obs !== exp_t[k]) begin errs++; $display("FAIL ovf_order%0d: got %h want %h", k, obs, exp_t[k]); end
        end
    endtask

    task automatic test_reset_mid_packet();
        int cnt = 0;
        do_reset();
        drive(4, mk(1'b1, 1'b0, 8'h50, 4'd3, 4'd2));
        tick();
        clear_in();
        drive(4, mk(1'b0, 1'b0, 8'h51, 4'd0, 4'd0));
        tick();
        clear_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 5'b0) begin errs++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        checks++; if (in_credit !== 5'b0) begin errs++; $display("FAIL mid_credit: got %b want 0", in_credit); end
        // Full credit count and a cleared lock let all four flits through output 0.
        for (int c = 0; c < 10; c++) begin
            clear_in();
            if (c < 4) drive(1, mk(1'b1, 1'b1, 8'(c), 4'd3, 4'd2));
            tick();
            if (out_valid[0]) cnt++;
        end
        clear_in();
        checks++; if (cnt !== 4) begin errs++; $display("FAIL mid_count: got %0d want 4", cnt); end
        drive(4, mk(1'b1, 1'b1, 8'h60, 4'd2, 4'd3));
        tick();
        clear_in();
        tick();
        checks++; if (out_valid !== 5'b00100) begin errs++; $display("FAIL mid_route: got %b want 00100", out_valid); end
    endtask

    initial begin
        rst        = 1'b1;
        out_credit = '0;
        in_valid   = '0;
        in_flit    = '0;
        test_reset();
        test_single_flit();
        test_all_ports();
        test_wormhole();
        test_credit_stall();
        test_round_robin();
        test_overflow();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
